// File: rtl/minute_hour_counter.sv
// minute_hour_counter: minutes/hours timekeeper with a three-state load path.
module minute_hour_counter #(
    parameter bit H24 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_rollover,
    input  logic       set_valid,
    input  logic [5:0] set_minutes,
    input  logic [4:0] set_hours,
    input  logic       set_pm,
    output logic       set_ready,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       hour_rollover,
    output logic       day_rollover,
    output logic       set_error
);
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
    state_t     r_state, w_next;
    logic [5:0] r_hold_min, r_min;
    logic [4:0] r_hold_hr, r_hr, w_hr_next;
    logic       r_hold_pm, r_pm, r_hr_roll, r_day_roll, r_err;
    logic       w_valid, w_pm_next, w_day;
    // State register for the load handshake.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // Next state, load validity and the hour-wrap arithmetic.
    always_comb begin
        w_next    = r_state == IDLE ? (set_valid ? CHECK : IDLE) : r_state == CHECK ? COMMIT : IDLE;
        set_ready = r_state == IDLE;
        w_valid   = r_hold_min <= 6'd59 && (H24 ? r_hold_hr <= 5'd23 : (r_hold_hr >= 5'd1 && r_hold_hr <= 5'd12));
        w_hr_next = H24 ? (r_hr >= 5'd23 ? 5'd0 : r_hr + 5'd1) : (r_hr >= 5'd12 ? 5'd1 : r_hr + 5'd1);
        w_pm_next = !H24 && (r_hr == 5'd11 ? !r_pm : r_pm);
        w_day     = H24 ? r_hr >= 5'd23 : (r_hr == 5'd11 && r_pm);
    end
    // Capture the requested time when a load is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_min <= '0;
            r_hold_hr  <= '0;
            r_hold_pm  <= 1'b0;
        end else if (set_valid && set_ready) begin
            r_hold_min <= set_minutes;
            r_hold_hr  <= set_hours;
            r_hold_pm  <= set_pm;
        end
    end
    // Error is registered at the end of CHECK so it is visible during COMMIT only.
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else r_err <= r_state == CHECK && !w_valid;
    end
    // Timekeeping: a commit overrides (and swallows) a coincident sec_rollover.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_min      <= '0;
            r_hr       <= H24 ? 5'd0 : 5'd12;
            r_pm       <= 1'b0;
            r_hr_roll  <= 1'b0;
            r_day_roll <= 1'b0;
        end else begin
            r_hr_roll  <= 1'b0;
            r_day_roll <= 1'b0;
            if (r_state == COMMIT) begin
                if (w_valid) begin
                    r_min <= r_hold_min;
                    r_hr  <= r_hold_hr;
                    r_pm  <= !H24 && r_hold_pm;
                end
            end else if (sec_rollover) begin
                if (r_min >= 6'd59) begin
                    r_min      <= '0;
                    r_hr       <= w_hr_next;
                    r_pm       <= w_pm_next;
                    r_hr_roll  <= 1'b1;
                    r_day_roll <= w_day;
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end
        end
    end
    assign minutes       = r_min;
    assign hours         = r_hr;
    assign pm            = r_pm;
    assign hour_rollover = r_hr_roll;
    assign day_rollover  = r_day_roll;
    assign set_error     = r_err;
endmodule

// File: tb/tb_minute_hour_counter.sv
// tb_minute_hour_counter: directed scoreboard bench for 24-hour (a) and 12-hour (b) instances.
module tb_minute_hour_counter;
    logic       clk = 1'b0, reset = 1'b1, sec = 1'b0, valid = 1'b0, spm = 1'b0;
    logic [5:0] smin = '0;
    logic [4:0] shr = '0;
    logic       a_rdy, a_pm, a_hr, a_day, a_err, b_rdy, b_pm, b_hr, b_day, b_err;
    logic [5:0] a_min, b_min;
    logic [4:0] a_hrs, b_hrs;
    logic [15:0] obs_a, obs_b;
    typedef struct {string tag; bit b; logic [15:0] exp;} exp_t;
    exp_t q[$];
    int n_run = 0, n_fail = 0;
    always #5 clk = ~clk;
    minute_hour_counter #(.H24(1'b1)) dut_a (
        .clk(clk), .reset(reset), .sec_rollover(sec), .set_valid(valid),
        .set_minutes(smin), .set_hours(shr), .set_pm(spm), .set_ready(a_rdy),
        .minutes(a_min), .hours(a_hrs), .pm(a_pm), .hour_rollover(a_hr),
        .day_rollover(a_day), .set_error(a_err));
    minute_hour_counter #(.H24(1'b0)) dut_b (
        .clk(clk), .reset(reset), .sec_rollover(sec), .set_valid(valid),
        .set_minutes(smin), .set_hours(shr), .set_pm(spm), .set_ready(b_rdy),
        .minutes(b_min), .hours(b_hrs), .pm(b_pm), .hour_rollover(b_hr),
        .day_rollover(b_day), .set_error(b_err));
    assign obs_a = {a_rdy, a_err, a_day, a_hr, a_pm, a_hrs, a_min};
    assign obs_b = {b_rdy, b_err, b_day, b_hr, b_pm, b_hrs, b_min};
    function automatic logic [15:0] v(input logic r, e, d, h, p, input logic [4:0] hr, input logic [5:0] mn);
        return {r, e, d, h, p, hr, mn};
    endfunction
    function automatic logic [15:0] tv(input logic p, input logic [4:0] hr, input logic [5:0] mn);
        return v(1'b1, 1'b0, 1'b0, 1'b0, p, hr, mn);
    endfunction
    task automatic exp2(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        q.push_back('{tag, 1'b0, ea});
        q.push_back('{tag, 1'b1, eb});
    endtask
    task automatic cycle;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t x = q.pop_front();
            logic [15:0] o = x.b ? obs_b : obs_a;
            n_run++;
            assert (o === x.exp) else begin
                n_fail++;
                $error("FAIL %s[%s]: got %h expected %h", x.tag, x.b ? "h12" : "h24", o, x.exp);
            end
        end
    endtask
    // Full load: accept, CHECK, COMMIT, back in IDLE. a0/b0 are idle vectors before the load.
    task automatic load(input string tag, input logic [5:0] mn, input logic [4:0] hr, input logic p,
                        input logic [15:0] a0, b0, a1, b1, input logic ea, eb);
        valid = 1'b1; smin = mn; shr = hr; spm = p;
        exp2({tag, "_chk"}, a0 & 16'h7fff, b0 & 16'h7fff);
        cycle();
        valid = 1'b0;
        exp2({tag, "_cmt"}, (a0 & 16'h7fff) | {1'b0, ea, 14'd0}, (b0 & 16'h7fff) | {1'b0, eb, 14'd0});
        cycle();
        exp2({tag, "_idle"}, a1, b1);
        cycle();
    endtask
    initial begin
        sec = 1'b1;
        valid = 1'b1;
        exp2("reset", tv(0, 0, 0), tv(0, 12, 0));
        cycle();
        reset = 1'b0; valid = 1'b0; sec = 1'b0;
        exp2("idle", tv(0, 0, 0), tv(0, 12, 0));
        cycle();
        for (int i = 0; i < 60; i++) begin
            sec = 1'b1;
            exp2("count", v(1, 0, 0, i == 59, 0, i == 59 ? 5'd1 : 5'd0, 6'((i + 1) % 60)),
                          v(1, 0, 0, i == 59, 0, i == 59 ? 5'd1 : 5'd12, 6'((i + 1) % 60)));
            cycle();
        end
        sec = 1'b0;
        exp2("count_end", tv(0, 1, 0), tv(0, 1, 0));
        cycle();
        load("ld2359", 59, 23, 0, tv(0, 1, 0), tv(0, 1, 0), tv(0, 23, 59), tv(0, 1, 0), 0, 1);
        sec = 1'b1;
        exp2("midnight24", v(1, 0, 1, 1, 0, 0, 0), tv(0, 1, 1));
        cycle();
        sec = 1'b0;
        exp2("pulse_end", tv(0, 0, 0), tv(0, 1, 1));
        cycle();
        load("ld1159p", 59, 11, 1, tv(0, 0, 0), tv(0, 1, 1), tv(0, 11, 59), tv(1, 11, 59), 0, 0);
        sec = 1'b1;
        exp2("midnight12", v(1, 0, 0, 1, 0, 12, 0), v(1, 0, 1, 1, 0, 12, 0));
        cycle();
        sec = 1'b0;
        load("ld1259", 59, 12, 0, tv(0, 12, 0), tv(0, 12, 0), tv(0, 12, 59), tv(0, 12, 59), 0, 0);
        sec = 1'b1;
        exp2("wrap12to1", v(1, 0, 0, 1, 0, 13, 0), v(1, 0, 0, 1, 0, 1, 0));
        cycle();
        sec = 1'b0;
        load("ld1159a", 59, 11, 0, tv(0, 13, 0), tv(0, 1, 0), tv(0, 11, 59), tv(0, 11, 59), 0, 0);
        sec = 1'b1;
        exp2("noon", v(1, 0, 0, 1, 0, 12, 0), v(1, 0, 0, 1, 1, 12, 0));
        cycle();
        sec = 1'b0;
        load("badmin", 60, 5, 0, tv(0, 12, 0), tv(1, 12, 0), tv(0, 12, 0), tv(1, 12, 0), 1, 1);
        load("hr0", 10, 0, 0, tv(0, 12, 0), tv(1, 12, 0), tv(0, 0, 10), tv(1, 12, 0), 0, 1);
        valid = 1'b1; smin = 30; shr = 10; spm = 0;
        exp2("ld1030_acc", v(0, 0, 0, 0, 0, 0, 10), v(0, 0, 0, 0, 1, 12, 0));
        cycle();
        valid = 1'b0; sec = 1'b1;
        exp2("sec_in_check", v(0, 0, 0, 0, 0, 0, 11), v(0, 0, 0, 0, 1, 12, 1));
        cycle();
        exp2("sec_in_commit", tv(0, 10, 30), tv(0, 10, 30));
        cycle();
        sec = 1'b0;
        exp2("after_commit", tv(0, 10, 30), tv(0, 10, 30));
        cycle();
        valid = 1'b1; smin = 5; shr = 5;
        exp2("rst_acc", v(0, 0, 0, 0, 0, 10, 30), v(0, 0, 0, 0, 0, 10, 30));
        cycle();
        valid = 1'b0; reset = 1'b1;
        exp2("rst_check", tv(0, 0, 0), tv(0, 12, 0));
        cycle();
        reset = 1'b0;
        exp2("rst_abort", tv(0, 0, 0), tv(0, 12, 0));
        cycle();
        exp2("rst_abort2", tv(0, 0, 0), tv(0, 12, 0));
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
